outport_alloc: RTL and testbench

OUTPORT_ALLOC -- requirements
Module: outport_alloc

---
 rtl/noc_pkg.sv | 22 ++
 rtl/outport_alloc_if.sv | 30 +++
 rtl/rr_arbiter.sv | 31 +++
 rtl/outport_alloc.sv | 108 ++++++++++
 tb/tb_outport_alloc.sv | 190 +++++++++++++++++++
 5 files changed

// File: rtl/noc_pkg.sv
// Shared NoC types: port count, port index names, credit depth, allocator FSM states.
// Imported by the output-port allocator, its arbiter and its interface.
package noc_pkg;

  localparam int NUM_PORTS   = 5;
  localparam int DEF_CREDITS = 4;
  localparam int CNT_W       = 3;

  typedef enum logic [2:0] {
    NORTH = 3'd0,
    SOUTH = 3'd1,
    EAST  = 3'd2,
    WEST  = 3'd3,
    LOCAL = 3'd4
  } port_e;

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } state_e;

endpackage

// File: rtl/outport_alloc_if.sv
// Output-port allocator bundle: per-input req/tail, downstream credit return,
// and grant/valid/credit/busy/overflow status. slave = allocator, master = driver.
interface outport_alloc_if
  import noc_pkg::*;
#(
  parameter int NUM_IN = NUM_PORTS
);

  logic [NUM_IN-1:0] req_i;
  logic [NUM_IN-1:0] tail_i;
  logic              credit_en_i;
  logic [NUM_IN-1:0] grant_o;
  logic              valid_o;
  logic [CNT_W-1:0]  credit_cnt_o;
  logic              busy_o;
  logic              overflow_o;

  modport slave (
    input  req_i, tail_i, credit_en_i,
    output grant_o, valid_o, credit_cnt_o,
    output busy_o, overflow_o
  );

  modport master (
    output req_i, tail_i, credit_en_i,
    input  grant_o, valid_o, credit_cnt_o,
    input  busy_o, overflow_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Stateless round-robin picker: first set req bit at or after ptr_i (mod N).
// Ports: req_i, ptr_i in; one-hot gnt_o, index idx_o, any_o out.
module rr_arbiter #(
  parameter int N  = 5,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic [IW-1:0] idx_o,
  output logic          any_o
);

  logic [IW-1:0] cand;

  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    any_o = 1'b0;
    cand  = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr_i) + i) % N);
      if (!any_o && req_i[cand]) begin
        any_o       = 1'b1;
        idx_o       = cand;
        gnt_o[cand] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/outport_alloc.sv
// Wormhole output-port allocator: round-robin packet lock plus credit flow control.
// Ports: clk, rst (async active-low), bus (outport_alloc_if.slave).
module outport_alloc
  import noc_pkg::*;
#(
  parameter int NUM_IN  = NUM_PORTS,
  parameter int CREDITS = DEF_CREDITS
) (
  input logic            clk,
  input logic            rst,
  outport_alloc_if.slave bus
);

  localparam int IW = $clog2(NUM_IN);
  localparam logic [CNT_W-1:0] CMAX = CNT_W'(CREDITS);
  localparam logic [IW-1:0] LAST = IW'(NUM_IN - 1);

  state_e            state_q, state_d;
  logic [IW-1:0]     ptr_q, ptr_d;
  logic [IW-1:0]     own_q, own_d;
  logic [NUM_IN-1:0] grant_q, grant_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              ovf_q, ovf_d;

  logic [NUM_IN-1:0] pick_oh;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic              locked;
  logic              valid;

  rr_arbiter #(
    .N  (NUM_IN),
    .IW (IW)
  ) u_arb (
    .req_i (bus.req_i),
    .ptr_i (ptr_q),
    .gnt_o (pick_oh),
    .idx_o (pick_idx),
    .any_o (pick_any)
  );

  assign locked = (state_q == LOCKED);
  assign valid  = locked && bus.req_i[own_q]
                  && (cnt_q != '0);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    own_d   = own_q;
    grant_d = grant_q;
    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          state_d = LOCKED;
          own_d   = pick_idx;
          grant_d = pick_oh;
        end
      end
      LOCKED: begin
        if (valid && bus.tail_i[own_q]) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = (own_q == LAST) ? '0
                    : own_q + IW'(1);
        end
      end
    endcase
  end

  // A returned credit and a sent flit in the same cycle cancel out.
  always_comb begin
    cnt_d = cnt_q;
    ovf_d = ovf_q;
    unique case ({bus.credit_en_i, valid})
      2'b10: begin
        if (cnt_q == CMAX) ovf_d = 1'b1;
        else cnt_d = cnt_q + CNT_W'(1);
      end
      2'b01:   cnt_d = cnt_q - CNT_W'(1);
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      own_q   <= '0;
      grant_q <= '0;
      cnt_q   <= CMAX;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      own_q   <= own_d;
      grant_q <= grant_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.grant_o      = grant_q;
  assign bus.valid_o      = valid;
  assign bus.credit_cnt_o = cnt_q;
  assign bus.busy_o       = locked;
  assign bus.overflow_o   = ovf_q;

endmodule

// File: tb/tb_outport_alloc.sv
// Self-checking bench for outport_alloc: vector table through a scoreboard
// queue, plus a hand-written latency / pointer-advance sequence.
module tb_outport_alloc;
  import noc_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  outport_alloc_if #(.NUM_IN(5)) bus ();

  outport_alloc #(
    .NUM_IN  (5),
    .CREDITS (4)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic [4:0] req;
    logic [4:0] tail;
    logic       cen;
    logic [4:0] g;
    logic       v;
    logic [2:0] cnt;
    logic       busy;
    logic       ovf;
  } vec_t;

  vec_t tbl[$];
  vec_t sb[$];
  int   checks = 0;
  int   errors = 0;

  function automatic vec_t mk(
    input logic       r,
    input logic [4:0] rq,
    input logic [4:0] tl,
    input logic       ce,
    input logic [4:0] g,
    input logic       v,
    input logic [2:0] c,
    input logic       b,
    input logic       o
  );
    vec_t t;
    t.rst = r;  t.req = rq; t.tail = tl;
    t.cen = ce; t.g = g;    t.v = v;
    t.cnt = c;  t.busy = b; t.ovf = o;
    return t;
  endfunction

  task automatic compare(input int idx);
    vec_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL row%0d: scoreboard empty", idx);
    end else begin
      e = sb.pop_front();
      if (bus.grant_o !== e.g || bus.valid_o !== e.v ||
          bus.credit_cnt_o !== e.cnt ||
          bus.busy_o !== e.busy ||
          bus.overflow_o !== e.ovf) begin
        errors++;
        $display("FAIL row%0d: got g=%b v=%b c=%0d b=%b o=%b want g=%b v=%b c=%0d b=%b o=%b",
                 idx, bus.grant_o, bus.valid_o,
                 bus.credit_cnt_o, bus.busy_o,
                 bus.overflow_o, e.g, e.v, e.cnt,
                 e.busy, e.ovf);
      end
    end
  endtask

  task automatic apply(input vec_t t, input int idx);
    @(posedge clk);
    #1;
    rst             = t.rst;
    bus.req_i       = t.req;
    bus.tail_i      = t.tail;
    bus.credit_en_i = t.cen;
    sb.push_back(t);
    #3;
    compare(idx);
  endtask

  task automatic chk(
    input string nm,
    input logic [7:0] got,
    input logic [7:0] want
  );
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", nm, got, want);
    end
  endtask

  initial begin
    int n;
    bus.req_i       = '0;
    bus.tail_i      = '0;
    bus.credit_en_i = 1'b0;

    // reset holds outputs even with traffic present
    tbl.push_back(mk(1'b0, 5'b11111, 5'b11111, 1'b1, 5'b0, 1'b0, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b0, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b0));
    // 3-flit packet from S
    tbl.push_back(mk(1'b1, 5'b00110, 5'b0, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00010, 5'b0, 1'b0, 5'b00010, 1'b1, 3'd4, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00010, 5'b0, 1'b0, 5'b00010, 1'b1, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00010, 5'b00010, 1'b0, 5'b00010, 1'b1, 3'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0, 3'd1, 1'b0, 1'b0));
    for (int i = 1; i <= 3; i++)
      tbl.push_back(mk(1'b1, 5'b0, 5'b0, 1'b1, 5'b0, 1'b0, 3'(i), 1'b0, 1'b0));
    // fairness from ptr=0
    tbl.push_back(mk(1'b0, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b0));
    for (int p = 0; p < 6; p++) begin
      tbl.push_back(mk(1'b1, 5'b11111, 5'b11111, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b0));
      tbl.push_back(mk(1'b1, 5'b11111, 5'b11111, 1'b1, 5'b00001 << (p % 5), 1'b1, 3'd4, 1'b1, 1'b0));
    end
    // credit stall, 6-flit packet from E
    tbl.push_back(mk(1'b1, 5'b00100, 5'b0, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b0));
    for (int i = 4; i >= 1; i--)
      tbl.push_back(mk(1'b1, 5'b00100, 5'b0, 1'b0, 5'b00100, 1'b1, 3'(i), 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00100, 5'b0, 1'b0, 5'b00100, 1'b0, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b11111, 5'b11011, 1'b0, 5'b00100, 1'b0, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00100, 5'b0, 1'b1, 5'b00100, 1'b0, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00100, 5'b0, 1'b0, 5'b00100, 1'b1, 3'd1, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00100, 5'b0, 1'b0, 5'b00100, 1'b0, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00100, 5'b0, 1'b1, 5'b00100, 1'b0, 3'd0, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00100, 5'b00100, 1'b0, 5'b00100, 1'b1, 3'd1, 1'b1, 1'b0));
    for (int i = 0; i <= 3; i++)
      tbl.push_back(mk(1'b1, 5'b0, 5'b0, 1'b1, 5'b0, 1'b0, 3'(i), 1'b0, 1'b0));
    // simultaneous credit+flit, owner drop, overflow
    tbl.push_back(mk(1'b1, 5'b00001, 5'b0, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00001, 5'b0, 1'b0, 5'b00001, 1'b1, 3'd4, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00001, 5'b0, 1'b0, 5'b00001, 1'b1, 3'd3, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00010, 5'b00010, 1'b0, 5'b00001, 1'b0, 3'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00001, 5'b0, 1'b1, 5'b00001, 1'b1, 3'd2, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b00001, 5'b00001, 1'b0, 5'b00001, 1'b1, 3'd2, 1'b1, 1'b0));
    for (int i = 1; i <= 4; i++)
      tbl.push_back(mk(1'b1, 5'b0, 5'b0, 1'b1, 5'b0, 1'b0, 3'(i), 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b1));
    tbl.push_back(mk(1'b1, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b1));
    // reset mid-packet at count 1
    tbl.push_back(mk(1'b0, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 5'b01000, 5'b0, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b0));
    for (int i = 4; i >= 2; i--)
      tbl.push_back(mk(1'b1, 5'b01000, 5'b0, 1'b0, 5'b01000, 1'b1, 3'(i), 1'b1, 1'b0));
    tbl.push_back(mk(1'b0, 5'b01000, 5'b0, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 5'b10000, 5'b0, 1'b0, 5'b0, 1'b0, 3'd4, 1'b0, 1'b0));
    tbl.push_back(mk(1'b1, 5'b10000, 5'b10000, 1'b0, 5'b10000, 1'b1, 3'd4, 1'b1, 1'b0));
    tbl.push_back(mk(1'b1, 5'b0, 5'b0, 1'b0, 5'b0, 1'b0, 3'd3, 1'b0, 1'b0));

    foreach (tbl[i]) apply(tbl[i], i);

    // request-to-grant latency, bounded wait; ptr now at N
    @(posedge clk);
    #1;
    bus.req_i  = 5'b01000;
    bus.tail_i = 5'b01000;
    n = 0;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
      n++;
      if (bus.busy_o) break;
    end
    chk("lat_cycles", 8'(n), 8'd1);
    chk("lat_grant", 8'(bus.grant_o), 8'h08);
    chk("lat_valid", 8'(bus.valid_o), 8'h01);
    chk("lat_cnt", 8'(bus.credit_cnt_o), 8'd3);
    bus.req_i = 5'b11111;
    @(posedge clk);
    #1;
    chk("bubble_busy", 8'(bus.busy_o), 8'h00);
    chk("bubble_cnt", 8'(bus.credit_cnt_o), 8'd2);
    @(posedge clk);
    #1;
    chk("ptr_adv_grant", 8'(bus.grant_o), 8'h10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
